fpu_wb_queue: RTL

- Result queue directly downstream of the FPU multiplier wrapper.
- Captures the wrapper's single-cycle, non-stallable result pulses (result, flags, dest reg) into a small FIFO.
- Presents queued results to the FP writeback arbiter over a valid/ready handshake.
- Counts operations in flight between start and result, and raises an issue stall so the multiplier can never produce a result with no free slot.

---
 rtl/fpu_wb_queue.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fpu_wb_queue.sv
// Writeback result queue behind the FPU multiplier: buffers non-stallable result
// pulses, hands them to the FP writeback arbiter, and stalls issue before a slot can run out.
package riscv_pkg;
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fp_flags_t;
endpackage

module fpu_wb_queue #(
  parameter int FP_WIDTH_D = 64,
  parameter int DEPTH      = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_start,
  input  logic                         i_valid,
  input  logic [FP_WIDTH_D-1:0]        i_result,
  input  riscv_pkg::fp_flags_t         i_flags,
  input  logic [4:0]                   i_dest_reg,
  output logic                         o_wb_valid,
  input  logic                         i_wb_ready,
  output logic [FP_WIDTH_D-1:0]        o_wb_result,
  output riscv_pkg::fp_flags_t         o_wb_flags,
  output logic [4:0]                   o_wb_dest_reg,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic [$clog2(DEPTH+1)-1:0]   o_inflight,
  output logic                         o_issue_stall,
  output logic                         o_error
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [FP_WIDTH_D-1:0]  res_mem [DEPTH];
  riscv_pkg::fp_flags_t   flg_mem [DEPTH];
  logic [4:0]             dst_mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic          error_q, error_d;

  logic push_en;
  logic pop_en;
  logic full;
  logic overflow;
  logic inf_underflow;
  logic inf_overflow;
  logic [CW:0] occupancy;

  always_comb begin
    full     = (count_q == FULL_C);
    pop_en   = (count_q != '0) & i_wb_ready;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    push_en  = i_valid & (~full | pop_en);
    overflow = i_valid & full & ~pop_en;

    wr_ptr_d = push_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop_en  ? rd_ptr_q + PW'(1) : rd_ptr_q;

    count_d = count_q;
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    inf_underflow = 1'b0;
    inf_overflow  = 1'b0;
    inflight_d    = inflight_q;
    if (i_start && !i_valid) begin
      if (inflight_q == FULL_C) inf_overflow = 1'b1;
      else                      inflight_d   = inflight_q + CW'(1);
    end else if (i_valid && !i_start) begin
      if (inflight_q == '0) inf_underflow = 1'b1;
      else                  inflight_d    = inflight_q - CW'(1);
    end

    error_d = error_q | overflow | inf_underflow | inf_overflow;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      error_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      error_q    <= error_d;
    end
  end

  // Entry storage carries data only; the pointers and count decide what is live.
  always_ff @(posedge i_clk) begin
    if (push_en) begin
      res_mem[wr_ptr_q] <= i_result;
      flg_mem[wr_ptr_q] <= i_flags;
      dst_mem[wr_ptr_q] <= i_dest_reg;
    end
  end

  assign occupancy     = {1'b0, count_q} + {1'b0, inflight_q};
  assign o_issue_stall = (occupancy >= {1'b0, FULL_C});

  assign o_wb_valid    = (count_q != '0);
  assign o_wb_result   = res_mem[rd_ptr_q];
  assign o_wb_flags    = flg_mem[rd_ptr_q];
  assign o_wb_dest_reg = dst_mem[rd_ptr_q];
  assign o_count       = count_q;
  assign o_inflight    = inflight_q;
  assign o_error       = error_q;

endmodule
